// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output stage: default widths, sample and
// accumulator types, and the round-half-up requantising shift.
package fir_pkg;

    localparam int FIR_INP_WIDTH  = 16;
    localparam int FIR_OUTP_WIDTH = 32;
    localparam int FIR_FRAC_BITS  = 15;
    localparam int FIR_L          = 3;
    localparam int FIR_FIFO_DEPTH = 4;

    typedef logic signed [FIR_INP_WIDTH-1:0]  sample_t;
    typedef logic signed [FIR_OUTP_WIDTH-1:0] acc_t;
    // One guard bit above the accumulator so the rounding bias cannot overflow.
    typedef logic signed [FIR_OUTP_WIDTH:0]   rnd_t;

    // Add half an output LSB, then drop the fraction bits arithmetically.
    // A zero shift returns the sign-extended input unchanged.
    function automatic rnd_t round_shift(input acc_t x, input int frac);
        rnd_t ext;
        rnd_t bias;
        ext  = {x[FIR_OUTP_WIDTH-1], x};
        bias = (frac > 0) ? (rnd_t'(1) <<< (frac - 1)) : '0;
        return (ext + bias) >>> frac;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through synchronous FIFO for requantised samples.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
// rd_data reads as zero while the FIFO is empty.
module fir_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when the same edge frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head of queue is visible without a pop (fall-through).
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Advance the write and read pointers.
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Write the storage array.
    // NOTE: storage has no reset; the pointers alone define which entries are valid, and empty masks rd_data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fir_output_stage.sv
// Consumer end of the FIR datapath: decimates by L, rounds half-up, narrows to
// INP_WIDTH and buffers results on a valid/ready stream. The filter cannot be
// stalled, so lost or clipped samples raise the sticky ovf flag.
// Optional feature: define FIR_OUT_SAT_EN to clamp out-of-range results
// (and flag each clamp); otherwise results wrap in two's complement.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int INP_WIDTH  = FIR_INP_WIDTH,
    parameter int OUTP_WIDTH = FIR_OUTP_WIDTH,
    parameter int L          = FIR_L,
    parameter int FRAC_BITS  = FIR_FRAC_BITS,
    parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [OUTP_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [INP_WIDTH-1:0] out_data,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int PW = (L > 1) ? $clog2(L) : 1;

`ifdef FIR_OUT_SAT_EN
    // Saturation needs the full rounded value to see how far out of range it is.
    localparam int S1_W = OUTP_WIDTH + 1;
    localparam logic signed [S1_W-1:0] SAT_MAX = S1_W'((64'sd1 <<< (INP_WIDTH - 1)) - 64'sd1);
    localparam logic signed [S1_W-1:0] SAT_MIN = ~SAT_MAX;
`else
    // Wrapping keeps only the low INP_WIDTH bits, so nothing wider is stored.
    localparam int S1_W = INP_WIDTH;
`endif

    logic [PW-1:0]               phase;
    logic                        keep;
    logic                        s1_valid;
    logic signed [S1_W-1:0]      s1_r;
    logic                        s2_valid;
    logic [INP_WIDTH-1:0]        s2_next;
    logic [INP_WIDTH-1:0]        s2_data;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [INP_WIDTH-1:0]        fifo_rd_data;
    logic                        drop;
    logic                        ovf_set;
`ifdef FIR_OUT_SAT_EN
    logic                        clip;
`endif

    // Keep inputs #0, #L, #2L, ... counted over valid cycles only.
    assign keep = in_valid & (phase == '0);

    // Phase counter advances on every valid input and wraps at L-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= (phase == PW'(L - 1)) ? '0 : phase + 1'b1;
        end
    end

    // Stage 1: round half-up and drop the fraction bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) s1_r <= S1_W'(round_shift(acc_t'(in_data), FRAC_BITS));
        end
    end

    // Narrow the rounded value to the output width (clamp or wrap).
    // NOTE: defaults come first so every path assigns each output; otherwise a latch is inferred.
    always_comb begin
        s2_next = s1_r[INP_WIDTH-1:0];
`ifdef FIR_OUT_SAT_EN
        clip = 1'b0;
        if (s1_r > SAT_MAX) begin
            s2_next = {1'b0, {(INP_WIDTH-1){1'b1}}};
            clip    = 1'b1;
        end else if (s1_r < SAT_MIN) begin
            s2_next = {1'b1, {(INP_WIDTH-1){1'b0}}};
            clip    = 1'b1;
        end
`endif
    end

    // Stage 2: register the narrowed sample ahead of the FIFO push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= s2_next;
        end
    end

    fir_out_fifo #(
        .WIDTH (INP_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s2_valid),
        .push_data (s2_data),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .rd_data   (fifo_rd_data)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_rd_data;

    // A full FIFO always has a head entry, so it can only make room through out_ready.
    assign drop = s2_valid & fifo_full & ~out_ready;

`ifdef FIR_OUT_SAT_EN
    assign ovf_set = drop | (s1_valid & clip);
`else
    assign ovf_set = drop;
`endif

    // Sticky loss flag; a new event in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_fir_output_stage.sv
// Self-checking bench for fir_output_stage (default widths, L=3, depth 4).
// Reference model: kept samples are requantised with plain longint arithmetic,
// delayed two cycles, then queued in a bounded list that drops when full.
module tb_fir_output_stage;
    import fir_pkg::*;

    localparam int IW    = 16;
    localparam int OW    = 32;
    localparam int LD    = 3;
    localparam int FB    = 15;
    localparam int DEPTH = 4;
    localparam longint MAXV = (longint'(1) <<< (IW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (IW - 1));

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [OW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [IW-1:0] out_data;
    logic                 ovf;
    logic                 ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int      due;
        sample_t val;
        bit      clip;
    } pend_t;

    pend_t   pend_q[$];
    sample_t mq[$];
    sample_t exp_q[$];
    sample_t obs_q[$];
    int      vcount = 0;
    int      cyc = 0;
    bit      m_ovf = 1'b0;

    fir_output_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void ref_requant(input logic signed [OW-1:0] x,
                                        output sample_t v, output bit clip);
        longint r;
        r    = (longint'(x) + (longint'(1) <<< (FB - 1))) >>> FB;
        clip = 1'b0;
`ifdef FIR_OUT_SAT_EN
        if (r > MAXV) begin
            r    = MAXV;
            clip = 1'b1;
        end else if (r < MINV) begin
            r    = MINV;
            clip = 1'b1;
        end
`endif
        v = r[IW-1:0];
    endfunction

    task automatic model_reset();
        pend_q.delete();
        mq.delete();
        exp_q.delete();
        obs_q.delete();
        vcount = 0;
        m_ovf  = 1'b0;
    endtask

    // Effect of one rising edge on the reference model, using pre-edge inputs.
    task automatic model_edge();
        int      pre;
        bit      pop;
        bit      set;
        pend_t   p;
        sample_t v;
        bit      c;
        pre = mq.size();
        pop = (pre > 0) && out_ready;
        set = 1'b0;
        if (pop) exp_q.push_back(mq.pop_front());
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            if (pre == DEPTH && !pop) set = 1'b1;
            else mq.push_back(pend_q[0].val);
            p = pend_q.pop_front();
        end
        foreach (pend_q[i]) if (pend_q[i].due == cyc + 1 && pend_q[i].clip) set = 1'b1;
        m_ovf = set || (m_ovf && !ovf_clr);
        if (in_valid) begin
            if (vcount % LD == 0) begin
                ref_requant(in_data, v, c);
                p.due  = cyc + 2;
                p.val  = v;
                p.clip = c;
                pend_q.push_back(p);
            end
            vcount++;
        end
        cyc++;
    endtask

    // Drive one cycle of inputs, log any transfer, advance one edge.
    task automatic step(input bit v, input logic [OW-1:0] d, input bit rdy, input bit clr);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        ovf_clr   = clr;
        #1;
        if (out_valid && out_ready) obs_q.push_back(out_data);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'sh0001_0000;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_data got %h want 0000", out_data); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        do_reset();
    endtask

    task automatic test_decimate();
        bit      exp_v;
        sample_t want[3];
        do_reset();
        want[0] = 16'sd1; want[1] = 16'sd4; want[2] = 16'sd7;
        for (int i = 0; i < 12; i++) begin
            step(i < 9, 32'(i + 1) << FB, 1'b1, 1'b0);
            exp_v = (i == 2) || (i == 5) || (i == 8);
            checks++;
            if (out_valid !== exp_v) begin
                errors++; $display("FAIL decim_valid cycle %0d got %b want %b", i, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_data !== sample_t'(i - 1)) begin
                    errors++; $display("FAIL decim_data cycle %0d got %0d want %0d", i, out_data, i - 1);
                end
            end
        end
        checks++;
        if (obs_q.size() != 3) begin
            errors++; $display("FAIL decim_count got %0d want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== want[i]) begin
                    errors++; $display("FAIL decim_seq[%0d] got %0d want %0d", i, obs_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_rounding();
        logic [OW-1:0] vals[3];
        sample_t       want[3];
        do_reset();
        vals[0] = 32'h0000_4000; vals[1] = 32'h0000_3FFF; vals[2] = 32'hFFFF_C000;
        want[0] = 16'sd1;        want[1] = 16'sd0;        want[2] = 16'sd0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vals[i], 1'b1, 1'b0);
            step(1'b1, '0, 1'b1, 1'b0);
            step(1'b1, '0, 1'b1, 1'b0);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_q.size() != 3) begin
            errors++; $display("FAIL round_count got %0d want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== want[i]) begin
                    errors++; $display("FAIL round[%0d] got %0d want %0d", i, obs_q[i], want[i]);
                end
            end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL round_ovf got %b want 0", ovf); end
    endtask

    task automatic test_clip();
        sample_t want_hi;
        sample_t want_lo;
        bit      want_ovf;
`ifdef FIR_OUT_SAT_EN
        want_hi = 16'h7FFF; want_lo = 16'h8000; want_ovf = 1'b1;
`else
        want_hi = 16'h8000; want_lo = 16'h0000; want_ovf = 1'b0;
`endif
        do_reset();
        step(1'b1, 32'h3FFF_FFFF, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clip_hi_valid got %b want 1", out_valid); end
        checks++; if (out_data !== want_hi) begin errors++; $display("FAIL clip_hi_data got %h want %h", out_data, want_hi); end
        checks++; if (ovf !== want_ovf) begin errors++; $display("FAIL clip_hi_ovf got %b want %b", ovf, want_ovf); end
        do_reset();
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (out_data !== want_lo) begin errors++; $display("FAIL clip_lo_data got %h want %h", out_data, want_lo); end
        checks++; if (ovf !== want_ovf) begin errors++; $display("FAIL clip_lo_ovf got %b want %b", ovf, want_ovf); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 32'(k) << FB, 1'b0, 1'b0);
            step(1'b1, '0, 1'b0, 1'b0);
            step(1'b1, '0, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b want 1", ovf); end
        checks++; if (out_data !== 16'sd1) begin errors++; $display("FAIL bp_head got %0d want 1", out_data); end
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_q.size() != 4) begin
            errors++; $display("FAIL bp_count got %0d want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_q[i] !== sample_t'(i + 1)) begin
                    errors++; $display("FAIL bp_seq[%0d] got %0d want %0d", i, obs_q[i], i + 1);
                end
            end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b want 1", ovf); end
        step(1'b0, '0, 1'b1, 1'b1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_clear got %b want 0", ovf); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 10; k <= 13; k++) begin
            step(1'b1, 32'(k) << FB, 1'b0, 1'b0);
            step(1'b1, '0, 1'b0, 1'b0);
            step(1'b1, '0, 1'b0, 1'b0);
        end
        // Sample 14 reaches the full FIFO on the only edge with out_ready high.
        step(1'b1, 32'(14) << FB, 1'b0, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0);
        step(1'b1, '0, 1'b1, 1'b0);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fp_ovf got %b want 0", ovf); end
        checks++; if (out_data !== 16'sd11) begin errors++; $display("FAIL fp_head got %0d want 11", out_data); end
        // Still holding four: one more kept sample must be dropped.
        step(1'b1, 32'(15) << FB, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL fp_full_ovf got %b want 1", ovf); end
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_q.size() != 5) begin
            errors++; $display("FAIL fp_count got %0d want 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_q[i] !== sample_t'(i + 10)) begin
                    errors++; $display("FAIL fp_seq[%0d] got %0d want %0d", i, obs_q[i], i + 10);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int j = 0; j < 8; j++) step(1'b1, (j % 3 == 0) ? (32'(j / 3 + 1) << FB) : 32'd0, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prevalid got %b want 1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL mid_data got %0d want 0", out_data); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'(5) << FB, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 16'sd5) begin
            errors++; $display("FAIL mid_after count %0d first %0d want 1 sample of 5",
                               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'sd0);
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) d = $urandom;
            else d = 32'(int'($urandom_range(0, 4194304)) - 2097152);
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
            checks++;
            if (out_valid !== (mq.size() > 0)) begin
                errors++; $display("FAIL rnd_valid cycle %0d got %b want %b", i, out_valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                checks++;
                if (out_data !== mq[0]) begin
                    errors++; $display("FAIL rnd_data cycle %0d got %h want %h", i, out_data, mq[0]);
                end
            end
            checks++;
            if (ovf !== m_ovf) begin
                errors++; $display("FAIL rnd_ovf cycle %0d got %b want %b", i, ovf, m_ovf);
            end
        end
        repeat (8) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rnd_stream_len got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rnd_stream[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_decimate();
        test_rounding();
        test_clip();
        test_backpressure();
        test_full_pop();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
